// File: rtl/qrs_event_pkg.sv
// Shared types and helpers for the multi-channel QRS event core.
// Sample, counter and RR widths are fixed here; channel count lives on the top.
package qrs_event_pkg;

  localparam int DATA_WIDTH = 11;
  localparam int CTR_WIDTH  = 22;
  localparam int RR_WIDTH   = 16;
  localparam int CNT_W      = 16;
  localparam int CH_W_MAX   = 8;

  typedef enum logic [1:0] {
    LEARN   = 2'd0,
    IDLE    = 2'd1,
    SEARCH  = 2'd2,
    REFRACT = 2'd3
  } ch_state_e;

  typedef struct packed {
    ch_state_e             state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] peak;
    logic [DATA_WIDTH-1:0] thr;
    logic [DATA_WIDTH-1:0] cand;
    logic [CTR_WIDTH-1:0]  cand_num;
    logic [CTR_WIDTH-1:0]  last_num;
    logic                  has_prev;
    logic [DATA_WIDTH-1:0] max;
  } ch_ctx_t;

  typedef struct packed {
    logic [CH_W_MAX-1:0]  ch;
    logic [CTR_WIDTH-1:0] sample_num;
    logic [RR_WIDTH-1:0]  rr;
    logic                 first;
  } evt_t;

  function automatic logic [DATA_WIDTH-1:0] thr_calc(input logic [DATA_WIDTH-1:0] peak,
                                                     input logic [DATA_WIDTH-1:0] thr_min);
    logic [DATA_WIDTH-1:0] half;
    half = peak >> 1;
    return (half > thr_min) ? half : thr_min;
  endfunction

  function automatic logic [RR_WIDTH-1:0] rr_sat(input logic [CTR_WIDTH-1:0] diff);
    if (diff > CTR_WIDTH'((1 << RR_WIDTH) - 1)) return '1;
    return diff[RR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/qrs_event_core_if.sv
// Sample input and event output bundle of the QRS event core.
// The core uses the slave view; the upstream/consumer side uses the master view.
interface qrs_event_core_if import qrs_event_pkg::*; #(
  parameter int N_CH = 4
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                  i_ce;
  logic [DATA_WIDTH-1:0] i_sample;
  logic [CH_W-1:0]       i_sample_ch;
  logic [CTR_WIDTH-1:0]  i_sample_num;
  logic                  i_sample_valid;
  logic                  o_evt_valid;
  logic                  i_evt_ready;
  logic [CH_W-1:0]       o_evt_ch;
  logic [CTR_WIDTH-1:0]  o_evt_sample_num;
  logic [RR_WIDTH-1:0]   o_evt_rr;
  logic                  o_evt_first;
  logic                  o_overflow;
  logic                  i_clr_overflow;
  logic [N_CH-1:0]       o_learning;

  modport slave (
    input  i_ce, i_sample, i_sample_ch, i_sample_num, i_sample_valid,
    input  i_evt_ready, i_clr_overflow,
    output o_evt_valid, o_evt_ch, o_evt_sample_num, o_evt_rr, o_evt_first,
    output o_overflow, o_learning
  );

  modport master (
    output i_ce, i_sample, i_sample_ch, i_sample_num, i_sample_valid,
    output i_evt_ready, i_clr_overflow,
    input  o_evt_valid, o_evt_ch, o_evt_sample_num, o_evt_rr, o_evt_first,
    input  o_overflow, o_learning
  );

endinterface

// File: rtl/qrs_event_core_ch_step.sv
// Next-context and event function for one channel on one accepted sample.
// Purely combinational; the top applies it to whichever context is addressed.
//
// state   | meaning
// LEARN   | tracking max over the first LEARN_LEN samples
// IDLE    | waiting for a sample above threshold
// SEARCH  | inside the QRS window, tracking the R-peak candidate
// REFRACT | ignoring samples after an event
module qrs_ch_step import qrs_event_pkg::*; #(
  parameter int LEARN_LEN   = 256,
  parameter int SEARCH_LEN  = 30,
  parameter int REFRACT_LEN = 50,
  parameter int THR_MIN     = 16
) (
  input  ch_ctx_t               ctx_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  input  logic [CTR_WIDTH-1:0]  sample_num_i,
  output ch_ctx_t               ctx_o,
  output logic                  fire_o,
  output logic [CTR_WIDTH-1:0]  evt_num_o,
  output logic [RR_WIDTH-1:0]   evt_rr_o,
  output logic                  evt_first_o
);

  localparam logic [DATA_WIDTH-1:0] THR_MIN_V  = DATA_WIDTH'(THR_MIN);
  localparam logic [CNT_W-1:0]      LEARN_TC   = CNT_W'(LEARN_LEN);
  localparam logic [CNT_W-1:0]      SEARCH_TC  = CNT_W'(SEARCH_LEN);
  localparam logic [CNT_W-1:0]      REFRACT_TC = CNT_W'(REFRACT_LEN);

  logic                  close;
  logic [CNT_W-1:0]      cnt_inc;
  logic [DATA_WIDTH+1:0] peak_mix;

  always_comb begin
    ctx_o       = ctx_i;
    fire_o      = 1'b0;
    evt_num_o   = '0;
    evt_rr_o    = '0;
    evt_first_o = 1'b0;
    close       = 1'b0;
    cnt_inc     = ctx_i.cnt + CNT_W'(1);
    peak_mix    = '0;

    case (ctx_i.state)
      LEARN: begin
        ctx_o.max = (sample_i > ctx_i.max) ? sample_i : ctx_i.max;
        ctx_o.cnt = cnt_inc;
        if (cnt_inc >= LEARN_TC) begin
          ctx_o.peak  = ctx_o.max;
          ctx_o.thr   = thr_calc(ctx_o.max, THR_MIN_V);
          ctx_o.state = IDLE;
          ctx_o.cnt   = '0;
        end
      end
      IDLE: begin
        if (sample_i > ctx_i.thr) begin
          ctx_o.state    = SEARCH;
          ctx_o.cand     = sample_i;
          ctx_o.cand_num = sample_num_i;
          ctx_o.cnt      = CNT_W'(1);
          close          = (SEARCH_TC <= CNT_W'(1));
        end
      end
      SEARCH: begin
        // strict compare: on ties the earlier sample stays the R-peak
        if (sample_i > ctx_i.cand) begin
          ctx_o.cand     = sample_i;
          ctx_o.cand_num = sample_num_i;
        end
        ctx_o.cnt = cnt_inc;
        close     = (cnt_inc >= SEARCH_TC);
      end
      REFRACT: begin
        ctx_o.cnt = cnt_inc;
        if (cnt_inc >= REFRACT_TC) begin
          ctx_o.state = IDLE;
          ctx_o.cnt   = '0;
        end
      end
      default: ctx_o.state = LEARN;
    endcase

    if (close) begin
      fire_o      = 1'b1;
      evt_num_o   = ctx_o.cand_num;
      evt_first_o = !ctx_i.has_prev;
      evt_rr_o    = ctx_i.has_prev ? rr_sat(ctx_o.cand_num - ctx_i.last_num) : '0;
      peak_mix    = ({2'b00, ctx_i.peak} << 1) + {2'b00, ctx_i.peak} + {2'b00, ctx_o.cand};
      ctx_o.peak     = DATA_WIDTH'(peak_mix >> 2);
      ctx_o.thr      = thr_calc(ctx_o.peak, THR_MIN_V);
      ctx_o.state    = REFRACT;
      ctx_o.cnt      = '0;
      ctx_o.last_num = ctx_o.cand_num;
      ctx_o.has_prev = 1'b1;
    end
  end

endmodule

// File: rtl/qrs_event_core.sv
// Multi-channel QRS detector: per-channel contexts stepped by one shared step
// function, with a single valid/ready event register and sticky overflow flag.
module qrs_event_core import qrs_event_pkg::*; #(
  parameter int N_CH        = 4,
  parameter int LEARN_LEN   = 256,
  parameter int SEARCH_LEN  = 30,
  parameter int REFRACT_LEN = 50,
  parameter int THR_MIN     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  qrs_event_core_if.slave  bus
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam ch_ctx_t RST_CTX = '{
    state:    LEARN,
    cnt:      '0,
    peak:     '0,
    thr:      DATA_WIDTH'(THR_MIN),
    cand:     '0,
    cand_num: '0,
    last_num: '0,
    has_prev: 1'b0,
    max:      '0
  };

  ch_ctx_t              ctx_q [N_CH];
  ch_ctx_t              ctx_sel;
  ch_ctx_t              ctx_nxt;
  evt_t                 evt_q, evt_d;
  logic                 evt_valid_q, evt_valid_d;
  logic                 ovf_q, ovf_d;
  logic                 accept;
  logic                 step_fire;
  logic                 fire;
  logic [CTR_WIDTH-1:0] step_num;
  logic [RR_WIDTH-1:0]  step_rr;
  logic                 step_first;

  assign accept = bus.i_ce && bus.i_sample_valid && (32'(bus.i_sample_ch) < N_CH);
  assign fire   = accept && step_fire;

  always_comb begin
    ctx_sel = ctx_q[0];
    for (int i = 0; i < N_CH; i++) begin
      if (bus.i_sample_ch == CH_W'(i)) ctx_sel = ctx_q[i];
    end
  end

  qrs_ch_step #(
    .LEARN_LEN   (LEARN_LEN),
    .SEARCH_LEN  (SEARCH_LEN),
    .REFRACT_LEN (REFRACT_LEN),
    .THR_MIN     (THR_MIN)
  ) u_step (
    .ctx_i        (ctx_sel),
    .sample_i     (bus.i_sample),
    .sample_num_i (bus.i_sample_num),
    .ctx_o        (ctx_nxt),
    .fire_o       (step_fire),
    .evt_num_o    (step_num),
    .evt_rr_o     (step_rr),
    .evt_first_o  (step_first)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_CH; i++) ctx_q[i] <= RST_CTX;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (accept && (bus.i_sample_ch == CH_W'(i))) ctx_q[i] <= ctx_nxt;
      end
    end
  end

  // The channel context advances even when its event is dropped, so RR stays
  // anchored to the true previous R-peak.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_d       = evt_q;
    ovf_d       = ovf_q;
    if (bus.i_ce) begin
      if (evt_valid_q && bus.i_evt_ready) evt_valid_d = 1'b0;
      if (bus.i_clr_overflow) ovf_d = 1'b0;
      if (fire) begin
        if (!evt_valid_d) begin
          evt_d.ch         = CH_W_MAX'(bus.i_sample_ch);
          evt_d.sample_num = step_num;
          evt_d.rr         = step_rr;
          evt_d.first      = step_first;
          evt_valid_d      = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      evt_q       <= '0;
      evt_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      evt_q       <= evt_d;
      evt_valid_q <= evt_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.o_evt_valid      = evt_valid_q;
  assign bus.o_evt_ch         = evt_q.ch[CH_W-1:0];
  assign bus.o_evt_sample_num = evt_q.sample_num;
  assign bus.o_evt_rr         = evt_q.rr;
  assign bus.o_evt_first      = evt_q.first;
  assign bus.o_overflow       = ovf_q;

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_learn
      assign bus.o_learning[g] = (ctx_q[g].state == LEARN);
    end
    if (CH_W < CH_W_MAX) begin : g_ch_pad
      logic ch_pad_unused;
      assign ch_pad_unused = |evt_q.ch[CH_W_MAX-1:CH_W];
    end
  endgenerate

endmodule

// File: tb/tb_qrs_event_core.sv
// Directed bench for qrs_event_core with short learn/search/refractory lengths.
// Three channels so that an out-of-range channel id (3) is representable.
module tb_qrs_event_core;
  import qrs_event_pkg::*;

  logic i_clk;
  logic i_rst;
  int   total;
  int   bad;

  qrs_event_core_if #(.N_CH(3)) bus ();

  qrs_event_core #(
    .N_CH        (3),
    .LEARN_LEN   (4),
    .SEARCH_LEN  (3),
    .REFRACT_LEN (2),
    .THR_MIN     (8)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input int ch, input int num, input int rr, input int first);
    chk({tag, ".valid"}, 32'(bus.o_evt_valid), 32'd1);
    chk({tag, ".ch"},    32'(bus.o_evt_ch), 32'(ch));
    chk({tag, ".num"},   32'(bus.o_evt_sample_num), 32'(num));
    chk({tag, ".rr"},    32'(bus.o_evt_rr), 32'(rr));
    chk({tag, ".first"}, 32'(bus.o_evt_first), 32'(first));
  endtask

  // One sample presented for exactly one rising edge; returns on the following
  // falling edge so any event it closed is already visible.
  task automatic smp(input int ch, input int v, input int n);
    @(negedge i_clk);
    bus.i_sample_ch    = 2'(ch);
    bus.i_sample       = 11'(v);
    bus.i_sample_num   = 22'(n);
    bus.i_sample_valid = 1'b1;
    @(negedge i_clk);
    bus.i_sample_valid = 1'b0;
  endtask

  task automatic pop();
    @(negedge i_clk);
    bus.i_evt_ready = 1'b1;
    @(negedge i_clk);
    bus.i_evt_ready = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    i_rst = 1'b1;
    bus.i_ce           = 1'b1;
    bus.i_sample       = '0;
    bus.i_sample_ch    = '0;
    bus.i_sample_num   = '0;
    bus.i_sample_valid = 1'b0;
    bus.i_evt_ready    = 1'b0;
    bus.i_clr_overflow = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("rst.valid",    32'(bus.o_evt_valid), 32'd0);
    chk("rst.ovf",      32'(bus.o_overflow), 32'd0);
    chk("rst.learning", 32'(bus.o_learning), 32'd7);
    chk("rst.num",      32'(bus.o_evt_sample_num), 32'd0);
    i_rst = 1'b0;

    // learn ch0: peak 40, thr 20
    smp(0, 10, 0); smp(0, 40, 1); smp(0, 20, 2);
    chk("learn.still", 32'(bus.o_learning), 32'd7);
    smp(0, 30, 3);
    chk("learn.done",  32'(bus.o_learning), 32'd6);
    chk("learn.noevt", 32'(bus.o_evt_valid), 32'd0);

    // first detection: R-peak 60@11; peak 45, thr 22
    smp(0, 25, 10); smp(0, 60, 11);
    chk("det.open", 32'(bus.o_evt_valid), 32'd0);
    smp(0, 50, 12);
    chk_evt("det", 0, 11, 0, 1);
    pop();
    chk("det.popped", 32'(bus.o_evt_valid), 32'd0);

    // refractory ignores 100s; 22 equals thr so no trigger
    smp(0, 100, 13); smp(0, 100, 14);
    chk("refr.noevt", 32'(bus.o_evt_valid), 32'd0);
    smp(0, 22, 15);
    smp(0, 30, 17); smp(0, 35, 18);
    chk("thr.eq", 32'(bus.o_evt_valid), 32'd0);
    smp(0, 20, 19);
    chk_evt("rr7", 0, 18, 7, 0);
    pop();
    smp(0, 0, 20); smp(0, 0, 21);

    // backpressure: first held, second dropped
    smp(0, 50, 30); smp(0, 0, 31); smp(0, 0, 32);
    chk_evt("bp1", 0, 30, 12, 0);
    smp(0, 0, 33); smp(0, 0, 34);
    smp(0, 50, 40); smp(0, 0, 41); smp(0, 0, 42);
    chk("bp.ovf",  32'(bus.o_overflow), 32'd1);
    chk("bp.held", 32'(bus.o_evt_sample_num), 32'd30);
    smp(0, 0, 43); smp(0, 0, 44);
    @(negedge i_clk);
    bus.i_clr_overflow = 1'b1;
    @(negedge i_clk);
    bus.i_clr_overflow = 1'b0;
    chk("clr.ovf",   32'(bus.o_overflow), 32'd0);
    chk("clr.valid", 32'(bus.o_evt_valid), 32'd1);

    // handshake and new event on the same edge; rr from dropped event's num 40
    smp(0, 50, 50); smp(0, 0, 51);
    @(negedge i_clk);
    bus.i_sample_ch    = 2'd0;
    bus.i_sample       = 11'd0;
    bus.i_sample_num   = 22'd52;
    bus.i_sample_valid = 1'b1;
    bus.i_evt_ready    = 1'b1;
    @(negedge i_clk);
    bus.i_sample_valid = 1'b0;
    bus.i_evt_ready    = 1'b0;
    chk_evt("same", 0, 50, 10, 0);
    chk("same.ovf", 32'(bus.o_overflow), 32'd0);
    pop();
    smp(0, 0, 53); smp(0, 0, 54);

    // interleave ch1 learning with a ch0 detection
    smp(1, 9, 60); smp(0, 30, 61); smp(1, 9, 62); smp(0, 0, 63); smp(1, 9, 64);
    smp(0, 0, 65);
    chk_evt("ilv", 0, 61, 11, 0);
    chk("ilv.learn3", 32'(bus.o_learning), 32'd6);
    pop();
    smp(1, 9, 66);
    chk("ilv.learn4", 32'(bus.o_learning), 32'd4);
    smp(3, 100, 67); smp(3, 100, 68); smp(3, 100, 69); smp(3, 100, 70);
    chk("ch3.learn", 32'(bus.o_learning), 32'd4);
    chk("ch3.noevt", 32'(bus.o_evt_valid), 32'd0);

    // counter wrap and RR saturation on ch1
    smp(1, 50, 4194302); smp(1, 0, 4194303); smp(1, 0, 0);
    chk_evt("wrap0", 1, 4194302, 0, 1);
    pop();
    smp(1, 0, 1); smp(1, 0, 2);
    smp(1, 50, 3); smp(1, 0, 4); smp(1, 0, 5);
    chk_evt("wrap", 1, 3, 5, 0);
    pop();
    smp(1, 0, 6); smp(1, 0, 7);
    smp(1, 50, 70008); smp(1, 0, 70009); smp(1, 0, 70010);
    chk_evt("sat", 1, 70008, 65535, 0);
    pop();
    smp(1, 0, 70011); smp(1, 0, 70012);
    smp(1, 50, 80000); smp(1, 0, 80001); smp(1, 0, 80002);
    chk_evt("rr9992", 1, 80000, 9992, 0);

    // ce low: no learning progress, ready ignored
    bus.i_ce        = 1'b0;
    bus.i_evt_ready = 1'b1;
    smp(2, 5, 90); smp(2, 5, 91); smp(2, 5, 92); smp(2, 5, 93);
    chk("ce.valid", 32'(bus.o_evt_valid), 32'd1);
    chk("ce.num",   32'(bus.o_evt_sample_num), 32'd80000);
    chk("ce.learn", 32'(bus.o_learning), 32'd4);
    bus.i_evt_ready = 1'b0;
    bus.i_ce        = 1'b1;

    // async reset mid-SEARCH with event pending
    smp(1, 0, 80003); smp(1, 0, 80004);
    smp(1, 50, 80010);
    @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    chk("arst.valid", 32'(bus.o_evt_valid), 32'd0);
    chk("arst.learn", 32'(bus.o_learning), 32'd7);
    chk("arst.ovf",   32'(bus.o_overflow), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    smp(1, 50, 80011);
    chk("arst.relearn", 32'(bus.o_learning), 32'd7);
    chk("arst.noevt",   32'(bus.o_evt_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
